// File: rtl/branch_resolve_unit.sv
// Branch/JAL/JALR resolution with a DEPTH-entry FIFO toward the frontend.
// Optional perf counters: define BRANCH_RESOLVE_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int XLEN      = 64,
  parameter int DEPTH     = 4,
  parameter int CF_TYPE_W = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   branch_valid_i,
  output logic                   branch_ready_o,
  input  logic [1:0]             op_i,
  input  logic [XLEN-1:0]        operand_a_i,
  input  logic [XLEN-1:0]        imm_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic                   is_compressed_i,
  input  logic                   comp_res_i,
  input  logic                   pred_taken_i,
  input  logic [XLEN-1:0]        pred_addr_i,
  input  logic [CF_TYPE_W-1:0]   pred_cf_type_i,
  output logic [XLEN-1:0]        result_o,
  output logic                   exception_valid_o,
  output logic [XLEN-1:0]        exception_tval_o,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [XLEN-1:0]        res_pc_o,
  output logic [XLEN-1:0]        res_target_o,
  output logic                   res_taken_o,
  output logic                   res_mispredict_o,
  output logic [CF_TYPE_W-1:0]   res_cf_type_o,
  output logic [$clog2(DEPTH):0] occupancy_o
`ifdef BRANCH_RESOLVE_PERF_CNT_EN
  ,
  output logic [31:0]            perf_branches_o,
  output logic [31:0]            perf_mispredicts_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] OP_JALR = 2'b01;
  localparam logic [1:0] OP_JAL  = 2'b10;

  logic            is_jalr;
  logic            is_jump;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] tgt_raw;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] next_pc;
  logic            taken;
  logic            mispredict;
  logic [XLEN-1:0] res_target;

  // Resolve the presented operation combinationally.
  always_comb begin
    is_jalr = (op_i == OP_JALR);
    is_jump = is_jalr | (op_i == OP_JAL);
    base    = is_jalr ? operand_a_i : pc_i;
    tgt_raw = base + imm_i;
    tgt     = {tgt_raw[XLEN-1:1], tgt_raw[0] & ~is_jalr};
    next_pc = pc_i + (is_compressed_i ? XLEN'(2) : XLEN'(4));
    taken   = is_jump | comp_res_i;
    if (is_jump)
      mispredict = ~pred_taken_i | (tgt != pred_addr_i);
    else
      mispredict = (taken != pred_taken_i);
    res_target = taken ? tgt : next_pc;
  end

  assign result_o          = next_pc;
  assign exception_valid_o = branch_valid_i & taken & tgt[0];
  assign exception_tval_o  = pc_i;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] occ;
  logic          empty;
  logic          enq;
  logic          deq;

  logic [XLEN-1:0]      pc_mem  [DEPTH];
  logic [XLEN-1:0]      tgt_mem [DEPTH];
  logic                 tkn_mem [DEPTH];
  logic                 mis_mem [DEPTH];
  logic [CF_TYPE_W-1:0] cf_mem  [DEPTH];

  assign occ            = wr_ptr_q - rd_ptr_q;
  assign empty          = (occ == '0);
  assign branch_ready_o = (occ != PW'(DEPTH));
  assign res_valid_o    = ~empty;
  assign occupancy_o    = occ;
  assign enq            = branch_valid_i & branch_ready_o & ~flush_i;
  assign deq            = res_valid_o & res_ready_i;

  // Pointer update; flush wins over any same-cycle enqueue or dequeue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Queue storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      pc_mem[wr_ptr_q[AW-1:0]]  <= pc_i;
      tgt_mem[wr_ptr_q[AW-1:0]] <= res_target;
      tkn_mem[wr_ptr_q[AW-1:0]] <= taken;
      mis_mem[wr_ptr_q[AW-1:0]] <= mispredict;
      cf_mem[wr_ptr_q[AW-1:0]]  <= pred_cf_type_i;
    end
  end

  // Head view, forced to zero while empty so stale storage never leaks.
  always_comb begin
    res_pc_o         = '0;
    res_target_o     = '0;
    res_taken_o      = 1'b0;
    res_mispredict_o = 1'b0;
    res_cf_type_o    = '0;
    if (!empty) begin
      res_pc_o         = pc_mem[rd_ptr_q[AW-1:0]];
      res_target_o     = tgt_mem[rd_ptr_q[AW-1:0]];
      res_taken_o      = tkn_mem[rd_ptr_q[AW-1:0]];
      res_mispredict_o = mis_mem[rd_ptr_q[AW-1:0]];
      res_cf_type_o    = cf_mem[rd_ptr_q[AW-1:0]];
    end
  end

`ifdef BRANCH_RESOLVE_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_br_d;
  logic [31:0] perf_mis_q, perf_mis_d;

  // Saturating event counters; flush does not clear them.
  always_comb begin
    perf_br_d  = perf_br_q;
    perf_mis_d = perf_mis_q;
    if (enq && perf_br_q != 32'hFFFF_FFFF)
      perf_br_d = perf_br_q + 32'd1;
    if (enq && mispredict && perf_mis_q != 32'hFFFF_FFFF)
      perf_mis_d = perf_mis_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      perf_br_q  <= perf_br_d;
      perf_mis_q <= perf_mis_d;
    end
  end

  assign perf_branches_o    = perf_br_q;
  assign perf_mispredicts_o = perf_mis_q;
`endif

endmodule
